// File: rtl/symbol_deframer.sv
// QPSK symbol deframer: packs 2-bit payload symbols MSB-first into bytes and queues them in a byte FIFO.
// Optional build macro DEFRAMER_DESCRAMBLE_EN XORs each payload byte with an x^7+x^6+1 LFSR sequence.
module symbol_deframer #(
   parameter int FRAME_SYMS   = 63,
   parameter int PAYLOAD_SYMS = 60,
   parameter int FIFO_DEPTH   = 16,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] in_data,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int CNT_W = $clog2(FRAME_SYMS + 1);
   localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PAD} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] sym_cnt_q;
   logic [IDL_W-1:0] idle_cnt_q;
   logic [5:0]       shift_q;
   logic             push_q;
   logic [7:0]       push_data_q;
   logic             push_last_q;
   logic             frame_err_q;

   logic             byte_done;
   logic             payload_end;
   logic             frame_end;
   logic             timeout;
   logic [7:0]       byte_d;

   assign byte_done   = in_valid && (state_q == S_PAYLOAD) && (sym_cnt_q[1:0] == 2'd3);
   assign payload_end = (sym_cnt_q == CNT_W'(PAYLOAD_SYMS - 1));
   assign frame_end   = (sym_cnt_q == CNT_W'(FRAME_SYMS - 1));
   assign timeout     = (idle_cnt_q == IDL_W'(IDLE_TIMEOUT - 1));

`ifdef DEFRAMER_DESCRAMBLE_EN
   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;
   logic [7:0] mask_d;

   // Eight serial LFSR steps unrolled; the output bit is the feedback bit.
   always_comb begin
      lfsr_d = lfsr_q;
      mask_d = '0;
      for (int i = 0; i < 8; i++) begin
         mask_d = {mask_d[6:0], lfsr_d[6] ^ lfsr_d[5]};
         lfsr_d = {lfsr_d[5:0], lfsr_d[6] ^ lfsr_d[5]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         lfsr_q <= 7'h7F;
      else if (in_valid && state_q == S_IDLE)
         lfsr_q <= 7'h7F;
      else if (byte_done)
         lfsr_q <= lfsr_d;
   end

   assign byte_d = {shift_q, in_data} ^ mask_d;
`else
   assign byte_d = {shift_q, in_data};
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sym_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         push_last_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               idle_cnt_q <= '0;
               if (in_valid) begin
                  shift_q   <= {4'b0, in_data};
                  sym_cnt_q <= CNT_W'(1);
                  state_q   <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (in_valid) begin
                  idle_cnt_q <= '0;
                  shift_q    <= {shift_q[3:0], in_data};
                  if (byte_done) begin
                     push_q      <= 1'b1;
                     push_data_q <= byte_d;
                     push_last_q <= payload_end;
                  end
                  if (payload_end && FRAME_SYMS > PAYLOAD_SYMS) begin
                     state_q   <= S_PAD;
                     sym_cnt_q <= sym_cnt_q + 1'b1;
                  end else if (payload_end) begin
                     state_q   <= S_IDLE;
                     sym_cnt_q <= '0;
                  end else begin
                     sym_cnt_q <= sym_cnt_q + 1'b1;
                  end
               end else if (timeout) begin
                  state_q     <= S_IDLE;
                  sym_cnt_q   <= '0;
                  idle_cnt_q  <= '0;
                  shift_q     <= '0;
                  frame_err_q <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            S_PAD: begin
               if (in_valid) begin
                  idle_cnt_q <= '0;
                  if (frame_end) begin
                     state_q   <= S_IDLE;
                     sym_cnt_q <= '0;
                  end else begin
                     sym_cnt_q <= sym_cnt_q + 1'b1;
                  end
               end else if (timeout) begin
                  state_q     <= S_IDLE;
                  sym_cnt_q   <= '0;
                  idle_cnt_q  <= '0;
                  shift_q     <= '0;
                  frame_err_q <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Byte FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, count;
   logic             overflow_q, overflow_d;
   logic             full, pop, push_ok;
   logic [8:0]       head;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign full      = (count == PTR_W'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push_ok   = push_q && (!full || pop);
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (push_ok)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_q && !push_ok)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage is not reset; the pointers define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q[AW-1:0]] <= {push_last_q, push_data_q};
   end

   // Outputs are gated so an empty FIFO presents zeros instead of stale storage.
   assign out_data  = out_valid ? head[7:0] : 8'h00;
   assign out_last  = out_valid ? head[8]   : 1'b0;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_symbol_deframer.sv
// Directed self-checking bench for symbol_deframer with default parameters and DEFRAMER_DESCRAMBLE_EN undefined.
module tb_symbol_deframer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] in_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       frame_err;
   logic       overflow;

   int total   = 0;
   int bad     = 0;
   int err_cnt = 0;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   symbol_deframer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   // Collect popped bytes and frame_err pulses mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready)
            got_q.push_back({out_last, out_data});
         if (frame_err)
            err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s);
      in_valid = 1'b1;
      in_data  = s;
      tick();
      in_valid = 1'b0;
      in_data  = 2'd0;
   endtask

   // pattern 0: 2,1,3,0 then zeros; pattern 1: i%4; pattern 2: (i/4)%4
   function automatic logic [1:0] sym(input int pat, input int i);
      case (pat)
         0:       case (i)
                     0: return 2'd2;
                     1: return 2'd1;
                     2: return 2'd3;
                     default: return 2'd0;
                  endcase
         1:       return 2'(i % 4);
         default: return 2'((i / 4) % 4);
      endcase
   endfunction

   function automatic logic [7:0] exp_byte(input int pat, input int k);
      case (pat)
         0:       return (k == 0) ? 8'h9C : 8'h00;
         1:       return 8'h1B;
         default: case (k % 4)
                     0: return 8'h00;
                     1: return 8'h55;
                     2: return 8'hAA;
                     default: return 8'hFF;
                  endcase
      endcase
   endfunction

   task automatic send_frame(input int pat, input int first, input int n);
      for (int i = first; i < first + n; i++)
         send(sym(pat, i));
   endtask

   task automatic expect_bytes(input int pat, input int n, input bit with_last);
      for (int k = 0; k < n; k++)
         exp_q.push_back({with_last && (k == n - 1), exp_byte(pat, k)});
   endtask

   task automatic check_bytes(input string tag);
      int n;
      check({tag, ".count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      got_q.delete();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
      repeat (3) tick();
      check("rst.out_valid", out_valid, 0);
      check("rst.out_last", out_last, 0);
      check("rst.out_data", out_data, 0);
      check("rst.frame_err", frame_err, 0);
      check("rst.overflow", overflow, 0);
      rst = 1'b0;
      tick();

      // Full frame with free-flowing output; PAD symbols must produce nothing.
      out_ready = 1'b1;
      send_frame(0, 0, 63);
      repeat (20) tick();
      expect_bytes(0, 15, 1);
      check_bytes("frame_a");

      send_frame(1, 0, 60);
      send(2'd3); send(2'd3); send(2'd3);
      repeat (20) tick();
      expect_bytes(1, 15, 1);
      check_bytes("frame_b");

      // Abort after 42 symbols: partial byte discarded, one frame_err, no out_last.
      send_frame(1, 0, 42);
      repeat (1023) tick();
      check("timeout.early", err_cnt, 0);
      repeat (10) tick();
      check("timeout.pulse", err_cnt, 1);
      expect_bytes(1, 10, 0);
      check_bytes("timeout");
      send_frame(0, 0, 63);
      repeat (20) tick();
      expect_bytes(0, 15, 1);
      check_bytes("after_timeout");
      check("timeout.single", err_cnt, 1);

      // Two frames with output stalled: 16 bytes kept, the rest dropped.
      out_ready = 1'b0;
      send_frame(2, 0, 63);
      send_frame(0, 0, 63);
      repeat (5) tick();
      check("ovf.sticky", overflow, 1);
      check("ovf.out_valid", out_valid, 1);
      check("ovf.stable_head", {out_last, out_data}, {1'b0, 8'h00});
      out_ready = 1'b1;
      repeat (30) tick();
      expect_bytes(2, 15, 1);
      exp_q.push_back({1'b0, 8'h9C});
      check_bytes("ovf.drain");
      check("ovf.empty", out_valid, 0);

      // Full FIFO plus a simultaneous push and pop must not drop.
      do_reset();
      check("full.ovf_cleared", overflow, 0);
      out_ready = 1'b0;
      send_frame(0, 0, 63);
      send_frame(0, 0, 4);
      repeat (5) tick();
      check("full.no_ovf_at_16", overflow, 0);
      send_frame(0, 4, 4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (3) tick();
      check("full.push_pop_ovf", overflow, 0);
      out_ready = 1'b1;
      repeat (30) tick();
      expect_bytes(0, 15, 1);
      exp_q.push_back({1'b0, 8'h9C});
      exp_q.push_back({1'b0, 8'h00});
      check_bytes("full.drain");

      // Reset at symbol 30 flushes FIFO and restarts framing.
      do_reset();
      out_ready = 1'b0;
      send_frame(1, 0, 30);
      check("midrst.pre_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      check("midrst.out_valid", out_valid, 0);
      check("midrst.out_data", out_data, 0);
      check("midrst.out_last", out_last, 0);
      rst = 1'b0;
      got_q.delete();
      out_ready = 1'b1;
      send_frame(1, 0, 63);
      repeat (20) tick();
      expect_bytes(1, 15, 1);
      check_bytes("midrst.frame");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
